// File: rtl/trace_pkg.sv
// Shared types for the retire trace monitor.
//   trace_kind_e : kind of a retired instruction
//   trace_rec_t  : one retire record as presented by a retire channel
//   trace_ent_t  : one trace FIFO entry, {instruction number, record}
//   mon_state_e  : monitor state machine states
package trace_pkg;

  typedef enum logic [2:0] {
    K_NOP   = 3'd0,  // branch or nop
    K_REG   = 3'd1,
    K_LOAD  = 3'd2,
    K_STORE = 3'd3,
    K_STU   = 3'd4,  // register write plus store
    K_HALT  = 3'd5
  } trace_kind_e;

  typedef struct packed {
    logic [15:0] pc;
    trace_kind_e kind;
    logic [2:0]  reg_idx;
    logic [15:0] reg_data;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
  } trace_rec_t;

  typedef struct packed {
    logic [31:0] inum;
    trace_rec_t  rec;
  } trace_ent_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DONE,
    ST_TIMEOUT
  } mon_state_e;

endpackage

// File: rtl/trace_fifo.sv
// Multi-push, single-pop trace FIFO.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset (pointers/count only)
//   push_cnt_i        : number of entries to write this edge (0..NUM_CH)
//   push_ent_i        : compacted entries, slot k written when k < push_cnt_i
//   pop_i             : remove the head entry this edge (caller guarantees non-empty)
//   head_o            : head entry, read straight from storage
//   count_o           : current occupancy
// The caller guarantees push_cnt_i never exceeds the free space before the edge.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$clog2(NUM_CH+1)-1:0]   push_cnt_i,
  input  trace_ent_t [NUM_CH-1:0]       push_ent_i,
  input  logic                          pop_i,
  output trace_ent_t                    head_o,
  output logic [$clog2(DEPTH+1)-1:0]    count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  trace_ent_t      mem_q [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   cnt_q;

  // Storage is data only and is not reset; the top masks the head while empty.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (k < int'(push_cnt_i)) begin
        mem_q[wr_q + AW'(k)] <= push_ent_i[k];
      end
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(push_cnt_i);
      rd_q  <= rd_q + AW'(pop_i);
      cnt_q <= cnt_q + CW'(push_cnt_i) - CW'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/retire_trace_mon.sv
// Retire trace monitor: samples up to NUM_CH retire channels per cycle,
// numbers the records, queues them in a trace FIFO and tracks halt/watchdog.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   ret_valid    : per-channel retire strobe
//   ret_rec      : per-channel retire record
//   out_valid    : head record available
//   out_ready    : consumer accepts head
//   out_rec      : head record (0 while empty)
//   out_inum     : instruction number of head record (0 while empty)
//   inst_count   : records retired so far, dropped ones included
//   cycle_count  : cycles spent in RUN
//   overflow     : sticky, a record was dropped
//   timeout      : watchdog expired (terminal)
//   done         : halt seen and FIFO drained (terminal)
module retire_trace_mon
  import trace_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DEPTH      = 16,
  parameter int MAX_CYCLES = 10000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       ret_valid,
  input  trace_rec_t [NUM_CH-1:0] ret_rec,
  output logic                    out_valid,
  input  logic                    out_ready,
  output trace_rec_t              out_rec,
  output logic [31:0]             out_inum,
  output logic [31:0]             inst_count,
  output logic [31:0]             cycle_count,
  output logic                    overflow,
  output logic                    timeout,
  output logic                    done
);

  localparam int PCW = $clog2(NUM_CH+1);
  localparam int CW  = $clog2(DEPTH+1);

  mon_state_e  state_q, state_d;
  logic [31:0] inst_count_q, inst_count_d;
  logic [31:0] cycle_count_q, cycle_count_d;
  logic        overflow_q, overflow_d;

  logic [CW-1:0]           fifo_cnt;
  trace_ent_t              fifo_head;
  trace_ent_t [NUM_CH-1:0] push_ent;
  logic [PCW-1:0]          push_cnt;
  logic                    pop;

  // Channel compaction scratch
  logic              halt_c;
  logic [NUM_CH-1:0] sel_c;
  int                nvalid_c;
  int                acc_c;
  int                free_c;
  int                pos_c [NUM_CH];

  assign out_valid = (fifo_cnt != '0);
  assign pop       = out_valid && out_ready;

  always_comb begin
    halt_c   = 1'b0;
    sel_c    = '0;
    nvalid_c = 0;
    acc_c    = 0;
    // Free space is taken before the edge; a same-cycle pop does not help.
    free_c   = DEPTH - int'(fifo_cnt);
    push_ent = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      pos_c[c] = 0;
      // A HALT masks every higher channel, but is itself counted.
      if ((state_q == ST_RUN) && ret_valid[c] && !halt_c) begin
        pos_c[c] = nvalid_c;
        if (nvalid_c < free_c) begin
          sel_c[c] = 1'b1;
          acc_c    = acc_c + 1;
        end
        nvalid_c = nvalid_c + 1;
        if (ret_rec[c].kind == K_HALT) begin
          halt_c = 1'b1;
        end
      end
    end
    // Pack accepted channels into consecutive FIFO slots, lowest channel first.
    for (int k = 0; k < NUM_CH; k++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (sel_c[c] && (pos_c[c] == k)) begin
          push_ent[k].inum = inst_count_q + 32'(k);
          push_ent[k].rec  = ret_rec[c];
        end
      end
    end
    push_cnt = PCW'(acc_c);
  end

  always_comb begin
    state_d       = state_q;
    inst_count_d  = inst_count_q;
    cycle_count_d = cycle_count_q;
    overflow_d    = overflow_q;
    case (state_q)
      ST_RUN: begin
        cycle_count_d = cycle_count_q + 32'd1;
        inst_count_d  = inst_count_q + 32'(nvalid_c);
        if (acc_c < nvalid_c) begin
          overflow_d = 1'b1;
        end
        // HALT takes priority over a simultaneous watchdog expiry.
        if (halt_c) begin
          state_d = ST_DRAIN;
        end else if (cycle_count_q == 32'(MAX_CYCLES - 1)) begin
          state_d = ST_TIMEOUT;
        end
      end
      ST_DRAIN: begin
        // Move on as soon as the last entry leaves, so done rises right after it pops.
        if ((fifo_cnt == '0) || ((fifo_cnt == CW'(1)) && pop)) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      inst_count_q  <= '0;
      cycle_count_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      inst_count_q  <= inst_count_d;
      cycle_count_q <= cycle_count_d;
      overflow_q    <= overflow_d;
    end
  end

  trace_fifo #(
    .NUM_CH (NUM_CH),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_cnt_i (push_cnt),
    .push_ent_i (push_ent),
    .pop_i      (pop),
    .head_o     (fifo_head),
    .count_o    (fifo_cnt)
  );

  // Storage is never reset, so the head is masked while the FIFO is empty.
  assign out_rec     = out_valid ? fifo_head.rec  : '0;
  assign out_inum    = out_valid ? fifo_head.inum : '0;
  assign inst_count  = inst_count_q;
  assign cycle_count = cycle_count_q;
  assign overflow    = overflow_q;
  assign timeout     = (state_q == ST_TIMEOUT);
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_retire_trace_mon.sv
// Directed testbench for retire_trace_mon (NUM_CH=2, DEPTH=16, MAX_CYCLES=100).
module tb_retire_trace_mon;
  import trace_pkg::*;

  logic             clk;
  logic             rst;
  logic [1:0]       ret_valid;
  trace_rec_t [1:0] ret_rec;
  logic             out_valid;
  logic             out_ready;
  trace_rec_t       out_rec;
  logic [31:0]      out_inum;
  logic [31:0]      inst_count;
  logic [31:0]      cycle_count;
  logic             overflow;
  logic             timeout;
  logic             done;

  int n_chk;
  int n_fail;

  retire_trace_mon #(
    .NUM_CH     (2),
    .DEPTH      (16),
    .MAX_CYCLES (100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ret_valid   (ret_valid),
    .ret_rec     (ret_rec),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rec     (out_rec),
    .out_inum    (out_inum),
    .inst_count  (inst_count),
    .cycle_count (cycle_count),
    .overflow    (overflow),
    .timeout     (timeout),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic trace_rec_t mk(input trace_kind_e k, input logic [15:0] pc);
    trace_rec_t r;
    r.pc       = pc;
    r.kind     = k;
    r.reg_idx  = pc[2:0];
    r.reg_data = pc ^ 16'hA5A5;
    r.mem_addr = pc + 16'h1000;
    r.mem_data = ~pc;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input trace_kind_e k0, input logic [15:0] pc0,
                       input logic v1, input trace_kind_e k1, input logic [15:0] pc1);
    ret_valid  = {v1, v0};
    ret_rec[0] = mk(k0, pc0);
    ret_rec[1] = mk(k1, pc1);
  endtask

  task automatic idle();
    drive(1'b0, K_NOP, 16'h0, 1'b0, K_NOP, 16'h0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    out_ready = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    out_ready = 1'b0;
    idle();
    #2;

    // Reset state
    check("rst_out_valid",   out_valid,   0);
    check("rst_inst_count",  inst_count,  0);
    check("rst_cycle_count", cycle_count, 0);
    check("rst_overflow",    overflow,    0);
    check("rst_timeout",     timeout,     0);
    check("rst_done",        done,        0);
    check("rst_out_inum",    out_inum,    0);
    check("rst_out_rec",     out_rec,     0);

    // Single-channel REG stream with consumer always ready
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, K_REG, 16'(2 * i), 1'b0, K_NOP, 16'h0);
      tick();
      check("a_out_valid", out_valid, 1);
      check("a_out_inum",  out_inum,  i);
      check("a_out_pc",    out_rec.pc, 2 * i);
    end
    idle();
    tick();
    check("a_empty",       out_valid,   0);
    check("a_overflow",    overflow,    0);
    check("a_inst_count",  inst_count,  3);
    check("a_cycle_count", cycle_count, 4);

    // Two channels in one cycle: ch0 first, ch1 next
    out_ready = 1'b0;
    drive(1'b1, K_STORE, 16'h0010, 1'b1, K_REG, 16'h0012);
    tick();
    check("b_inst_count", inst_count, 5);
    check("b_inum0",      out_inum,   3);
    check("b_pc0",        out_rec.pc, 16'h0010);
    check("b_kind0",      out_rec.kind, K_STORE);
    check("b_mdata0",     out_rec.mem_data, 16'hFFEF);
    idle();
    out_ready = 1'b1;
    tick();
    check("b_inum1", out_inum,   4);
    check("b_pc1",   out_rec.pc, 16'h0012);
    check("b_kind1", out_rec.kind, K_REG);
    tick();
    check("b_empty", out_valid, 0);

    // Overflow: 17 records into a 16-deep FIFO
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, K_REG, 16'(2 * i), 1'b0, K_NOP, 16'h0);
      tick();
      if (i == 15) check("c_no_ovf_at_16", overflow, 0);
    end
    idle();
    check("c_overflow",   overflow,   1);
    check("c_inst_count", inst_count, 17);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("c_valid", out_valid, 1);
      check("c_inum",  out_inum,  i);
      check("c_pc",    out_rec.pc, 2 * i);
      tick();
    end
    check("c_drained",    out_valid, 0);
    check("c_ovf_sticky", overflow,  1);

    // HALT on ch0 masks ch1; drain then done
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, K_REG, 16'(16'h20 + 2 * i), 1'b0, K_NOP, 16'h0);
      tick();
    end
    drive(1'b1, K_HALT, 16'h0040, 1'b1, K_REG, 16'h0042);
    tick();
    check("d_inst_count", inst_count, 4);
    drive(1'b1, K_REG, 16'h0050, 1'b1, K_REG, 16'h0052);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("d_valid",  out_valid, 1);
      check("d_inum",   out_inum,  i);
      check("d_done_0", done,      0);
      if (i == 3) begin
        check("d_halt_pc",   out_rec.pc,   16'h0040);
        check("d_halt_kind", out_rec.kind, K_HALT);
      end
      tick();
    end
    check("d_done",       done,       1);
    check("d_empty",      out_valid,  0);
    check("d_ignored",    inst_count, 4);
    tick();
    check("d_done_hold",  done,       1);

    // Asynchronous reset in the middle of DRAIN
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, K_LOAD, 16'(16'h100 + i), 1'b0, K_NOP, 16'h0);
      tick();
    end
    drive(1'b1, K_HALT, 16'h0200, 1'b0, K_NOP, 16'h0);
    tick();
    idle();
    check("e_pre_valid", out_valid,  1);
    check("e_pre_ovf",   overflow,   1);
    check("e_pre_cnt",   inst_count, 18);
    #2;
    rst = 1'b1;
    #1;
    check("e_valid",   out_valid,   0);
    check("e_inum",    out_inum,    0);
    check("e_rec",     out_rec,     0);
    check("e_icount",  inst_count,  0);
    check("e_ccount",  cycle_count, 0);
    check("e_ovf",     overflow,    0);
    check("e_timeout", timeout,     0);
    check("e_done",    done,        0);
    #1;
    rst = 1'b0;
    drive(1'b1, K_REG, 16'h0300, 1'b0, K_NOP, 16'h0);
    tick();
    idle();
    check("e_next_valid", out_valid,  1);
    check("e_next_inum",  out_inum,   0);
    check("e_next_pc",    out_rec.pc, 16'h0300);
    check("e_next_cnt",   inst_count, 1);

    // Watchdog: 100 RUN cycles without HALT
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 99; i++) tick();
    check("f_ccount_99", cycle_count, 99);
    check("f_no_to_yet", timeout,     0);
    tick();
    check("f_timeout",    timeout,     1);
    check("f_ccount_100", cycle_count, 100);
    drive(1'b1, K_REG, 16'h0400, 1'b1, K_HALT, 16'h0402);
    tick();
    idle();
    check("f_ignored",    inst_count,  0);
    check("f_no_out",     out_valid,   0);
    check("f_frozen",     cycle_count, 100);
    check("f_done",       done,        0);
    check("f_to_sticky",  timeout,     1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
